// File: rtl/rr_arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: the controller
// state encoding and the requester-count / select-width constants.
package rr_arb_pkg;

  // Number of requesters and width of the grant index.
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Controller states. IDLE picks a winner; BUSY holds the grant.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage : rr_arb_pkg

// File: rtl/rr_priority_picker.sv
// Rotating-priority picker: scans requests starting at i_ptr and wrapping
// modulo NUM_REQ, returning the first asserted requester as a one-hot
// vector and as an index. Purely combinational.
module rr_priority_picker
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_found
);

  logic [SEL_W-1:0] w_cand;

  // Walk ptr, ptr+1, ... (wrapping in SEL_W bits) and keep the first hit.
  always_comb begin
    o_found  = 1'b0;
    o_idx    = i_ptr;
    o_onehot = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = i_ptr + SEL_W'(k);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (o_found) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule : rr_priority_picker

// File: rtl/four_way_rr_arbiter.sv
// Four-way round-robin arbiter with a 4:1 data router.
// A grant is issued from IDLE one clock after a request is seen and held
// in BUSY until the granted requester signals last or drops its request.
// Each release returns to IDLE for one cycle and moves the priority
// pointer just past the released requester.
// Optional macro RR_ARB_TIMEOUT_EN adds a hold counter that force-releases
// a grant after MAX_HOLD cycles and pulses the timeout output.
//
// Handshake: out_valid is high while a grant is held and the granted
// requester still asserts req; the requester ends its transfer by raising
// last together with req, which completes on that rising edge.
module four_way_rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [N-1:0]       in_data0,
  input  logic [N-1:0]       in_data1,
  input  logic [N-1:0]       in_data2,
  input  logic [N-1:0]       in_data3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [N-1:0]       out_data,
  output logic               out_valid
`ifdef RR_ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  // Registered state.
  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;

  // Next-state values.
  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [SEL_W-1:0]   w_ptr_nxt;

  // Picker results.
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_found;

  // Release decision terms.
  logic               w_busy;
  logic               w_req_sel;
  logic               w_last_sel;
  logic               w_norm_rel;
  logic               w_limit;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;
`else
  // MAX_HOLD only matters with the hold limit enabled.
  logic               w_unused_hold;
  assign w_unused_hold = (MAX_HOLD != 0);
`endif

  rr_priority_picker u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_busy     = (r_state == ST_BUSY);
  assign w_req_sel  = req[r_sel];
  assign w_last_sel = last[r_sel];
  // Release when the owner finishes (req & last) or abandons (req low).
  assign w_norm_rel = ~w_req_sel | w_last_sel;

`ifdef RR_ARB_TIMEOUT_EN
  assign w_limit = (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
  assign w_limit = 1'b0;
`endif

  // Next-state logic for the IDLE/BUSY controller.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
`ifdef RR_ARB_TIMEOUT_EN
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_pick_onehot;
          w_sel_nxt   = w_pick_idx;
`ifdef RR_ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end else begin
          // No requests: keep gnt clear, sel holds its last value.
          w_gnt_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (w_norm_rel || w_limit) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
          // Only a forced release reports a timeout.
          w_timeout_nxt = w_limit & ~w_norm_rel;
          w_hold_nxt    = '0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          w_hold_nxt = r_hold + HOLD_W'(1);
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset overrides any grant or release on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  // Route the granted lane straight through; zero when no grant is held.
  always_comb begin
    out_data = '0;
    if (w_busy) begin
      unique case (r_sel)
        2'd0:    out_data = in_data0;
        2'd1:    out_data = in_data1;
        2'd2:    out_data = in_data2;
        default: out_data = in_data3;
      endcase
    end
  end

  assign out_valid = w_busy & w_req_sel;
  assign gnt       = r_gnt;
  assign sel       = r_sel;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeout   = r_timeout;
`endif

endmodule : four_way_rr_arbiter

// File: doc/four_way_rr_arbiter.md
FOUR_WAY_RR_ARBITER -- requirements
Module: four_way_rr_arbiter

Interface
REQ-001 Parameter N, default 5, data width of each requester lane and of the routed output.
REQ-002 Parameter MAX_HOLD, default 16, maximum grant length in cycles (used only under REQ-030).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester request; bit i = requester i.
REQ-006 last  input  4  per-requester end-of-transfer marker, sampled only for the granted requester.
REQ-007 in_data0..in_data3  input  N each  requester data lanes.
REQ-008 gnt  output  4  registered one-hot grant, or all-zero.
REQ-009 sel  output  2  registered index of the granted requester; drives the 4:1 routing select.
REQ-010 out_data  output  N  routed data; in_data[sel] when busy, else all-zero.
REQ-011 out_valid  output  1  high when busy and req[sel] is high.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-013 IDLE: when req != 0, SHALL choose the first asserted bit scanning ptr, ptr+1, ... mod 4, and load gnt/sel on that edge; BUSY next cycle (latency: 1 clock from req to gnt).
REQ-014 IDLE with req == 0: SHALL stay IDLE with gnt = 0 and sel unchanged.
REQ-015 BUSY: gnt and sel SHALL stay constant regardless of other requests.
REQ-016 BUSY: on an edge where req[sel] & last[sel] is high, or where req[sel] is low, SHALL release: gnt -> 0, state -> IDLE, ptr -> sel+1 mod 4.
REQ-017 Release SHALL always insert exactly one IDLE cycle before the next grant (no back-to-back grants).
REQ-018 ptr SHALL be 2 bits and wrap 3 -> 0; after releasing requester 3, requester 0 has top priority.
REQ-019 last on non-granted bits and last without req SHALL be ignored.
REQ-020 out_data/out_valid SHALL be combinational from registered state and current inputs; no extra latency.
REQ-021 Requests dropping in the same cycle a grant is issued SHALL still yield a one-cycle BUSY, then release per REQ-016.

Reset
REQ-022 On rst high at a clock edge: state = IDLE, gnt = 0, sel = 0, ptr = 0, hold counter = 0, timeout = 0.
REQ-023 rst SHALL override every other event, including a release or grant in the same cycle.
REQ-024 Reset mid-BUSY SHALL drop gnt at that edge with no pointer advance.

Configuration
REQ-030 Macro RR_ARB_TIMEOUT_EN: when defined, adds output timeout (1 bit) and a hold counter of width $clog2(MAX_HOLD+1).
REQ-031 With macro: counter clears on entering BUSY and increments each BUSY cycle; if no REQ-016 release when counter == MAX_HOLD-1, SHALL force release per REQ-016 and pulse timeout high for exactly the following cycle.
REQ-032 With macro: if last and the limit coincide, normal release SHALL apply and timeout SHALL stay low.
REQ-033 Without macro: no timeout port, no counter; a grant is held until REQ-016 release.

Structure
REQ-040 Shared package rr_arb_pkg SHALL hold the FSM state enum, NUM_REQ = 4 and the select width constant 2.
REQ-041 A sub-module rr_priority_picker (req, ptr -> one-hot winner and index, purely combinational) SHALL be used; everything else lives in four_way_rr_arbiter.

Verification
REQ-050 rst=1 for 2 cycles with req=4'b1111 -> gnt=0, sel=0, out_valid=0, out_data=0 throughout.
REQ-051 ptr=0, req=4'b0110 -> gnt=4'b0010, sel=1 one cycle later; last[1]=1 -> gnt=0 next cycle, then gnt=4'b0100.
REQ-052 All four requesting continuously, each asserting last on its 3rd granted cycle -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-053 Granted to 2, in_data2=5'h15 -> out_data=5'h15, out_valid=1; drop req[2] -> release next edge, ptr=3.
REQ-054 With RR_ARB_TIMEOUT_EN, MAX_HOLD=16, req[0] held, no last -> gnt=4'b0001 for exactly 16 cycles, then gnt=0 and timeout=1 for one cycle.
REQ-055 rst pulsed in 3rd BUSY cycle of requester 3 -> gnt=0 next edge, then with req=4'b1001 grant goes to 0 (ptr=0).
